// File: rtl/bcd_stopwatch_counter_if.sv
// Control/status bundle for bcd_stopwatch_counter: pulse controls in, packed BCD and flags out.
interface bcd_stopwatch_counter_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  run_toggle;
  logic                  clear;
  logic                  dir;
  logic                  lap;
  logic [4*DIGITS-1:0]   bcd;
  logic                  running;
  logic                  tick;
  logic                  wrap;

  modport master (
    output run_toggle, clear, dir, lap,
    input  bcd, running, tick, wrap
  );

  modport slave (
    input  run_toggle, clear, dir, lap,
    output bcd, running, tick, wrap
  );
endinterface

// File: rtl/bcd_stopwatch_counter.sv
// Multi-digit BCD up/down stopwatch counter with prescaler, run/pause/clear and wrap flag.
// Optional lap display hold is built only when STOPWATCH_LAP_EN is defined.
module bcd_stopwatch_counter #(
  parameter int unsigned         DIV     = 10_000_000,
  parameter int unsigned         DIGITS  = 4,
  parameter logic [4*DIGITS-1:0] MAX_BCD = {DIGITS{4'h9}}
) (
  input  logic                    clk,
  input  logic                    rst_n,
  bcd_stopwatch_counter_if.slave  bus
);

  localparam int unsigned     PW         = $clog2(DIV);
  localparam int unsigned     CW         = 4 * DIGITS;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

  state_e          r_state, w_state_next;
  logic [PW-1:0]   r_presc, w_presc_next;
  logic [CW-1:0]   r_count, w_count_next, w_count_step;
  logic            w_step, w_wrap_step;
  logic            r_running, r_tick, r_wrap;

  always_comb begin
    w_state_next = r_state;
    if (bus.clear) begin
      w_state_next = StIdle;
    end else if (bus.run_toggle) begin
      unique case (r_state)
        StIdle:  w_state_next = StRun;
        StRun:   w_state_next = StPause;
        StPause: w_state_next = StRun;
        default: w_state_next = StIdle;
      endcase
    end
  end

  // clear suppresses a coincident step, so tick/wrap stay low on that edge
  assign w_step = (r_state == StRun) && (r_presc == PRESC_LAST) && !bus.clear;

  always_comb begin
    w_presc_next = r_presc;
    if (bus.clear) begin
      w_presc_next = '0;
    end else if (r_state == StRun) begin
      w_presc_next = (r_presc == PRESC_LAST) ? '0 : r_presc + PW'(1);
    end
  end

  // Digit-serial carry/borrow chain; the count never passes through binary
  always_comb begin
    logic w_carry;
    w_count_step = r_count;
    w_wrap_step  = 1'b0;
    w_carry      = 1'b1;
    if (!bus.dir) begin
      if (r_count == MAX_BCD) begin
        w_count_step = '0;
        w_wrap_step  = 1'b1;
      end else begin
        for (int i = 0; i < int'(DIGITS); i++) begin
          if (w_carry) begin
            if (r_count[4*i +: 4] == 4'd9) begin
              w_count_step[4*i +: 4] = 4'd0;
            end else begin
              w_count_step[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
              w_carry                = 1'b0;
            end
          end
        end
      end
    end else begin
      if (r_count == '0) begin
        w_count_step = MAX_BCD;
        w_wrap_step  = 1'b1;
      end else begin
        for (int i = 0; i < int'(DIGITS); i++) begin
          if (w_carry) begin
            if (r_count[4*i +: 4] == 4'd0) begin
              w_count_step[4*i +: 4] = 4'd9;
            end else begin
              w_count_step[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
              w_carry                = 1'b0;
            end
          end
        end
      end
    end
  end

  always_comb begin
    w_count_next = r_count;
    if (bus.clear) begin
      w_count_next = '0;
    end else if (w_step) begin
      w_count_next = w_count_step;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_presc   <= '0;
      r_count   <= '0;
      r_running <= 1'b0;
      r_tick    <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_presc   <= w_presc_next;
      r_count   <= w_count_next;
      r_running <= (w_state_next == StRun);
      r_tick    <= w_step;
      r_wrap    <= w_step & w_wrap_step;
    end
  end

  assign bus.running = r_running;
  assign bus.tick    = r_tick;
  assign bus.wrap    = r_wrap;

`ifdef STOPWATCH_LAP_EN
  logic            r_hold_en, w_hold_en_next;
  logic [CW-1:0]   r_hold, w_hold_next, r_bcd;

  always_comb begin
    w_hold_en_next = r_hold_en;
    w_hold_next    = r_hold;
    if (bus.clear) begin
      w_hold_en_next = 1'b0;
    end else if (bus.lap) begin
      w_hold_en_next = !r_hold_en;
      if (!r_hold_en) begin
        w_hold_next = r_count;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_en <= 1'b0;
      r_hold    <= '0;
      r_bcd     <= '0;
    end else begin
      r_hold_en <= w_hold_en_next;
      r_hold    <= w_hold_next;
      r_bcd     <= w_hold_en_next ? w_hold_next : w_count_next;
    end
  end

  assign bus.bcd = r_bcd;
`else
  assign bus.bcd = r_count;
`endif

endmodule

// File: tb/tb_bcd_stopwatch_counter.sv
// Directed bench for bcd_stopwatch_counter: 2-digit DUT (DIV=4, MAX=12) plus a 4-digit DUT.
module tb_bcd_stopwatch_counter;

`ifdef STOPWATCH_LAP_EN
  localparam bit LapEn = 1'b1;
`else
  localparam bit LapEn = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  bcd_stopwatch_counter_if #(.DIGITS(2)) bus  ();
  bcd_stopwatch_counter_if #(.DIGITS(4)) bus4 ();

  bcd_stopwatch_counter #(.DIV(4), .DIGITS(2), .MAX_BCD(8'h12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  bcd_stopwatch_counter #(.DIV(4), .DIGITS(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  // which: 0 run_toggle, 1 clear, 2 lap
  task automatic pulse(input int which);
    @(negedge clk);
    case (which)
      0: bus.run_toggle = 1'b1;
      1: bus.clear      = 1'b1;
      default: bus.lap  = 1'b1;
    endcase
    @(negedge clk);
    bus.run_toggle = 1'b0;
    bus.clear      = 1'b0;
    bus.lap        = 1'b0;
  endtask

  // Returns negedges until tick is seen, or -1 if the bound expires
  task automatic wait_tick(input int limit, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!bus.tick && cycles < limit);
    if (!bus.tick) cycles = -1;
  endtask

  task automatic test_reset();
    bus.run_toggle = 0; bus.clear = 0; bus.dir = 0; bus.lap = 0;
    bus4.run_toggle = 0; bus4.clear = 0; bus4.dir = 0; bus4.lap = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (bus.bcd !== 8'h00) begin bad++; $display("FAIL reset_bcd: got %h want 00", bus.bcd); end
    total++;
    if (bus.running !== 1'b0 || bus.tick !== 1'b0 || bus.wrap !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: got run=%b tick=%b wrap=%b want 0 0 0",
               bus.running, bus.tick, bus.wrap);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_count_up();
    int cyc;
    pulse(0);
    total++;
    if (bus.running !== 1'b1) begin bad++; $display("FAIL start_running: got %b want 1", bus.running); end
    wait_tick(10, cyc);
    total++;
    if (cyc !== 4 || bus.bcd !== 8'h01) begin
      bad++; $display("FAIL first_tick: got cyc=%0d bcd=%h want cyc=4 bcd=01", cyc, bus.bcd);
    end
    for (int i = 2; i <= 10; i++) wait_tick(10, cyc);
    total++;
    if (cyc !== 4 || bus.bcd !== 8'h10) begin
      bad++; $display("FAIL ten_steps: got cyc=%0d bcd=%h want cyc=4 bcd=10", cyc, bus.bcd);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_b [3];
    logic       exp_w [3];
    int         cyc;
    exp_b = '{8'h11, 8'h12, 8'h00};
    exp_w = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      wait_tick(10, cyc);
      total++;
      if (cyc < 0 || bus.bcd !== exp_b[i] || bus.wrap !== exp_w[i]) begin
        bad++;
        $display("FAIL up_wrap[%0d]: got bcd=%h wrap=%b want bcd=%h wrap=%b",
                 i, bus.bcd, bus.wrap, exp_b[i], exp_w[i]);
      end
    end
    @(negedge clk);
    total++;
    if (bus.wrap !== 1'b0 || bus.tick !== 1'b0) begin
      bad++; $display("FAIL wrap_one_cycle: got wrap=%b tick=%b want 0 0", bus.wrap, bus.tick);
    end
    bus.dir = 1'b1;
    wait_tick(10, cyc);
    total++;
    if (cyc !== 3 || bus.bcd !== 8'h12 || bus.wrap !== 1'b1) begin
      bad++;
      $display("FAIL down_wrap: got cyc=%0d bcd=%h wrap=%b want cyc=3 bcd=12 wrap=1",
               cyc, bus.bcd, bus.wrap);
    end
    wait_tick(10, cyc);
    total++;
    if (bus.bcd !== 8'h11 || bus.wrap !== 1'b0) begin
      bad++; $display("FAIL down_step: got bcd=%h wrap=%b want bcd=11 wrap=0", bus.bcd, bus.wrap);
    end
    bus.dir = 1'b0;
  endtask

  task automatic test_pause();
    int cyc;
    bit ok;
    pulse(0);
    total++;
    if (bus.running !== 1'b0) begin bad++; $display("FAIL pause_running: got %b want 0", bus.running); end
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.tick !== 1'b0 || bus.bcd !== 8'h11) ok = 1'b0;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL pause_hold: got bcd=%h tick=%b want bcd=11 tick=0", bus.bcd, bus.tick); end
    pulse(0);
    wait_tick(10, cyc);
    total++;
    if (cyc !== 2 || bus.bcd !== 8'h12) begin
      bad++; $display("FAIL resume_step: got cyc=%0d bcd=%h want cyc=2 bcd=12", cyc, bus.bcd);
    end
  endtask

  task automatic test_clear_run();
    int cyc;
    bit ok;
    pulse(1);
    total++;
    if (bus.bcd !== 8'h00 || bus.running !== 1'b0) begin
      bad++; $display("FAIL clear: got bcd=%h run=%b want 00 0", bus.bcd, bus.running);
    end
    pulse(0);
    for (int i = 0; i < 7; i++) wait_tick(10, cyc);
    total++;
    if (bus.bcd !== 8'h07) begin bad++; $display("FAIL reach_07: got %h want 07", bus.bcd); end
    // Line clear and run_toggle up with the next step edge
    repeat (2) @(negedge clk);
    @(negedge clk);
    bus.clear = 1'b1; bus.run_toggle = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0; bus.run_toggle = 1'b0;
    total++;
    if (bus.bcd !== 8'h00 || bus.running !== 1'b0 || bus.tick !== 1'b0 || bus.wrap !== 1'b0) begin
      bad++;
      $display("FAIL clear_wins: got bcd=%h run=%b tick=%b wrap=%b want 00 0 0 0",
               bus.bcd, bus.running, bus.tick, bus.wrap);
    end
    ok = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (bus.tick !== 1'b0 || bus.running !== 1'b0) ok = 1'b0;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL idle_quiet: got tick=%b run=%b want 0 0", bus.tick, bus.running); end
  endtask

  task automatic test_lap();
    int         cyc;
    logic [7:0] e;
    pulse(0);
    for (int i = 0; i < 5; i++) wait_tick(10, cyc);
    total++;
    if (bus.bcd !== 8'h05) begin bad++; $display("FAIL lap_reach_05: got %h want 05", bus.bcd); end
    pulse(2);
    for (int k = 1; k <= 3; k++) begin
      wait_tick(10, cyc);
      e = LapEn ? 8'h05 : 8'(5 + k);
      total++;
      if (cyc < 0 || bus.bcd !== e) begin
        bad++; $display("FAIL lap_hold[%0d]: got cyc=%0d bcd=%h want bcd=%h", k, cyc, bus.bcd, e);
      end
    end
    pulse(2);
    total++;
    if (bus.bcd !== 8'h08) begin bad++; $display("FAIL lap_release: got %h want 08", bus.bcd); end
    wait_tick(10, cyc);
    pulse(2);
    pulse(1);
    total++;
    if (bus.bcd !== 8'h00 || bus.running !== 1'b0) begin
      bad++; $display("FAIL lap_clear: got bcd=%h run=%b want 00 0", bus.bcd, bus.running);
    end
    pulse(0);
    wait_tick(10, cyc);
    total++;
    if (cyc !== 4 || bus.bcd !== 8'h01) begin
      bad++; $display("FAIL after_lap_clear: got cyc=%0d bcd=%h want cyc=4 bcd=01", cyc, bus.bcd);
    end
  endtask

  task automatic test_digits4();
    int cnt;
    int cyc;
    @(negedge clk); bus4.run_toggle = 1'b1;
    @(negedge clk); bus4.run_toggle = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4100 && cnt < 999; i++) begin
      @(negedge clk);
      if (bus4.tick) cnt++;
    end
    total++;
    if (cnt !== 999 || bus4.bcd !== 16'h0999) begin
      bad++; $display("FAIL d4_reach_0999: got steps=%0d bcd=%h want 999 0999", cnt, bus4.bcd);
    end
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!bus4.tick && cyc < 8);
    total++;
    if (!bus4.tick || bus4.bcd !== 16'h1000 || bus4.wrap !== 1'b0) begin
      bad++; $display("FAIL d4_carry: got bcd=%h wrap=%b want 1000 0", bus4.bcd, bus4.wrap);
    end
    bus4.dir = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!bus4.tick && cyc < 8);
    total++;
    if (!bus4.tick || bus4.bcd !== 16'h0999) begin
      bad++; $display("FAIL d4_borrow: got tick=%b bcd=%h want 1 0999", bus4.tick, bus4.bcd);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (bus.bcd !== 8'h00 || bus.running !== 1'b0 || bus4.bcd !== 16'h0000) begin
      bad++;
      $display("FAIL async_reset: got bcd=%h run=%b bcd4=%h want 00 0 0000",
               bus.bcd, bus.running, bus4.bcd);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_count_up();
    test_wrap();
    test_pause();
    test_clear_run();
    test_lap();
    test_digits4();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
